// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: Y86-64 F/D/E pipeline registers and condition codes with stall/bubble control.
// Define PIPE_STATS_EN to add saturating stall_cnt/bubble_cnt event counters.
module pipe_stage_regs #(
  parameter int W = 64,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      f_predPC_in,
  input  logic [20+2*W-1:0] d_bus_in,
  input  logic [28+3*W-1:0] e_bus_in,
  input  logic [2:0]        cc_in,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic              E_bubble,
  input  logic              set_cc,
  output logic [W-1:0]      F_predPC,
  output logic [20+2*W-1:0] d_bus,
  output logic [28+3*W-1:0] e_bus,
  output logic [2:0]        cc,
`ifdef PIPE_STATS_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt,
`endif
  output logic              ctrl_err
);
  localparam logic [20+2*W-1:0] D_NOP = {4'b1000, 4'h1, 4'h0, 8'hFF, {(2*W){1'b0}}};
  localparam logic [28+3*W-1:0] E_NOP = {4'b1000, 4'h1, 4'h0, 16'hFFFF, {(3*W){1'b0}}};
  logic e_opq;
  // CC write is qualified by the instruction currently held in E, not the one entering
  assign e_opq = e_bus[20+3*W +: 4] == 4'h6;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_predPC <= RESET_PC;
      d_bus    <= D_NOP;
      e_bus    <= E_NOP;
      cc       <= 3'b100;
      ctrl_err <= 1'b0;
    end else begin
      if (!F_stall) F_predPC <= f_predPC_in;
      if (!D_stall) d_bus <= D_bubble ? D_NOP : d_bus_in;
      e_bus <= E_bubble ? E_NOP : e_bus_in;
      if (set_cc && e_opq) cc <= cc_in;
      if (D_stall && D_bubble) ctrl_err <= 1'b1;
    end
  end
`ifdef PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if ((F_stall || D_stall) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if ((D_bubble || E_bubble) && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif
endmodule
